instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8-style datapath.
- Fetches each instruction into an instruction register (IR) and classifies its opcode.
- Selects the matching per-class decoder's control word, K and nextState, and steps the 2-bit state until the decoder returns state 00.
- Stalls on memory handshakes and halts on illegal opcodes or runaway sequences.

Parameters:
- NUM_CLASSES, 8, number of per-class decoders on the dec_* buses.
- MAX_EXEC_CYCLES, 8, EXEC cycles allowed per instruction before forced halt.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_data  in  32  instruction word from memory, valid when mem_ready=1.
- mem_ready  in  1  memory access completes this cycle.
- dec_cw  in  31*NUM_CLASSES  control words from decoders; class i occupies [31*i+30:31*i].
- dec_ns  in  2*NUM_CLASSES  nextState from decoders.
- dec_k  in  64*NUM_CLASSES  K constants from decoders.
- instruction  out  32  IR contents, fanned to all decoders.
- state  out  2  current micro-state, fanned to all decoders.
- controlWord  out  31  {Psel[2],DA[5],SA[5],SB[5],Fsel[5],regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}.
- K  out  64  selected constant.
- fetch  out  1  high in FETCH.
- halted  out  1  high in HALT.

Behaviour:
- FSM states: FETCH, EXEC, HALT.
- Reset values: FSM=FETCH, IR=0, state=00, cycle count=0, halted=0.
- FETCH:
  - controlWord = FETCH_CW: EN_MEM=1, all else 0, Psel=00; K=0.
  - When mem_ready=1: Psel=01 (PC<-PC+4) that cycle, IR<=mem_data on the edge, state<=00, next EXEC.
  - When mem_ready=0: hold, PC unchanged.
- Class decode is combinational on IR[31:21] in EXEC:
  - 0 ALU_R: 1xx0101x000.
  - 1 ALU_I: 1xx100xxxx.
  - 2 MEM: 11111000000, 11111000010.
  - 3 B: x00101.
  - 4 BR: 11010110000.
  - 5 CB: 1011010x.
  - 6 BCOND: 01010100.
  - 7 MOV: 1x1100101.
  - First match wins in that order; no match = illegal.
- EXEC, legal opcode:
  - controlWord, K and next state are taken from class c's slice.
  - Stall: if the slice has EN_MEM=1 or ramW=1 and mem_ready=0, output the slice with regW=0 and Psel=00 forced, and hold state and count.
  - Otherwise: if dec_ns=00, go to FETCH; else state<=dec_ns and stay in EXEC.
  - Cycle count increments each non-stall EXEC cycle and clears on entry to FETCH.
- EXEC, illegal opcode: output NOP (all zero), go to HALT next edge.
- Watchdog: if the count reaches MAX_EXEC_CYCLES with dec_ns≠00, go to HALT instead of advancing.
- HALT: controlWord=0, K=0, halted=1; sticky until reset_n low.
- reset_n low at any point, including mid-EXEC or mid-stall, returns to FETCH with IR=0 immediately and asynchronously. No write enable may be asserted while reset_n=0.
- State wrap: the decoder may drive dec_ns=01..11 in any order. The sequencer does no arithmetic on state; it only copies it.
- All outputs are driven combinationally from registered state and IR plus mem_ready/dec_*. Latency: instruction visible one edge after fetch completes.

Optional Feature:
- Macro: INSTR_SEQ_PERF_EN.
- When defined, adds outputs instr_retired[31:0] and stall_cycles[31:0].
  - instr_retired increments on each EXEC->FETCH transition.
  - stall_cycles increments on each stalled cycle in FETCH or EXEC.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - control-word field widths and bit offsets;
  - FETCH_CW and NOP_CW constants;
  - the class enum ALU_R..MOV;
  - the opcode prefix masks and values;
  - the FSM state typedef.
- One sub-module, instr_class_decode: IR[31:21] -> class index and illegal flag. It is purely combinational and shared with the verification model.

Test Plan:
- BR X3, IR=0xD61F0060, mem_ready=1, dec 4 returns cw with PCsel=1 and ns=00 -> one EXEC cycle with controlWord equal to dec 4's slice, then fetch=1.
- LDUR with mem_ready held 0 for 3 EXEC cycles, decoder ns 00->01->00 -> state holds at the stall point, regW=0 and Psel=00 during the stall, 2 retired EXEC cycles, back to FETCH.
- FETCH with mem_ready low for 2 cycles -> Psel=00 for those cycles; Psel=01 and IR load on the ready cycle.
- Illegal opcode, IR=0x00000000 -> one NOP cycle then halted=1, controlWord=0; halted persists 10 cycles until reset_n=0.
- Decoder stuck at ns=01 -> HALT after exactly 8 EXEC cycles.
- reset_n asserted mid-EXEC at state=10 -> same-cycle fetch=1, state=00, instruction=0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer: control-word layout,
// fixed control words, opcode class table and FSM encoding.
package instr_sequencer_pkg;

    localparam int CW_W   = 31;
    localparam int PSEL_W = 2;
    localparam int REG_W  = 5;
    localparam int FSEL_W = 5;
    localparam int OPC_W  = 11;

    // Control word is {Psel,DA,SA,SB,Fsel,regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}
    localparam int CW_SL       = 0;
    localparam int CW_PCSEL    = 1;
    localparam int CW_BSEL     = 2;
    localparam int CW_EN_PC    = 3;
    localparam int CW_EN_B     = 4;
    localparam int CW_EN_ALU   = 5;
    localparam int CW_EN_MEM   = 6;
    localparam int CW_RAMW     = 7;
    localparam int CW_REGW     = 8;
    localparam int CW_FSEL_LSB = 9;
    localparam int CW_SB_LSB   = CW_FSEL_LSB + FSEL_W;
    localparam int CW_SA_LSB   = CW_SB_LSB + REG_W;
    localparam int CW_DA_LSB   = CW_SA_LSB + REG_W;
    localparam int CW_PSEL_LSB = CW_DA_LSB + REG_W;

    localparam logic [PSEL_W-1:0] PSEL_HOLD = 2'b00;
    localparam logic [PSEL_W-1:0] PSEL_INC  = 2'b01;

    localparam logic [CW_W-1:0] FETCH_CW = 31'h0000_0040;
    localparam logic [CW_W-1:0] NOP_CW   = 31'h0000_0000;
    // Bits that may modify architectural state (PC, register file, RAM)
    localparam logic [CW_W-1:0] WRITE_EN_MASK = 31'h6000_0180;

    typedef enum logic [2:0] {
        CLS_ALU_R = 3'd0,
        CLS_ALU_I = 3'd1,
        CLS_MEM   = 3'd2,
        CLS_B     = 3'd3,
        CLS_BR    = 3'd4,
        CLS_CB    = 3'd5,
        CLS_BCOND = 3'd6,
        CLS_MOV   = 3'd7
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    // Opcode prefixes are left-aligned on IR[31:21]; don't-care bits are masked off
    localparam logic [OPC_W-1:0] ALU_R_MASK = 11'b100_1111_0111;
    localparam logic [OPC_W-1:0] ALU_R_VAL  = 11'b100_0101_0000;
    localparam logic [OPC_W-1:0] ALU_I_MASK = 11'b100_1110_0000;
    localparam logic [OPC_W-1:0] ALU_I_VAL  = 11'b100_1000_0000;
    localparam logic [OPC_W-1:0] MEM_MASK   = 11'b111_1111_1101;
    localparam logic [OPC_W-1:0] MEM_VAL    = 11'b111_1100_0000;
    localparam logic [OPC_W-1:0] B_MASK     = 11'b011_1110_0000;
    localparam logic [OPC_W-1:0] B_VAL      = 11'b000_1010_0000;
    localparam logic [OPC_W-1:0] BR_MASK    = 11'b111_1111_1111;
    localparam logic [OPC_W-1:0] BR_VAL     = 11'b110_1011_0000;
    localparam logic [OPC_W-1:0] CB_MASK    = 11'b111_1111_0000;
    localparam logic [OPC_W-1:0] CB_VAL     = 11'b101_1010_0000;
    localparam logic [OPC_W-1:0] BCOND_MASK = 11'b111_1111_1000;
    localparam logic [OPC_W-1:0] BCOND_VAL  = 11'b010_1010_0000;
    localparam logic [OPC_W-1:0] MOV_MASK   = 11'b101_1111_1100;
    localparam logic [OPC_W-1:0] MOV_VAL    = 11'b101_1001_0100;

    function automatic logic opcode_match(input logic [OPC_W-1:0] opc,
                                          input logic [OPC_W-1:0] mask,
                                          input logic [OPC_W-1:0] value);
        return ((opc & mask) == value);
    endfunction

endpackage

// File: rtl/instr_sequencer_class_decode.sv
// Combinational opcode classifier: IR[31:21] -> class index, first match wins.
module instr_class_decode
    import instr_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output instr_class_e     class_o,
    output logic             illegal_o
);

    // Priority match in class order; anything unmatched is illegal
    always_comb begin
        class_o   = CLS_ALU_R;
        illegal_o = 1'b0;
        if (opcode_match(opcode_i, ALU_R_MASK, ALU_R_VAL)) begin
            class_o = CLS_ALU_R;
        end else if (opcode_match(opcode_i, ALU_I_MASK, ALU_I_VAL)) begin
            class_o = CLS_ALU_I;
        end else if (opcode_match(opcode_i, MEM_MASK, MEM_VAL)) begin
            class_o = CLS_MEM;
        end else if (opcode_match(opcode_i, B_MASK, B_VAL)) begin
            class_o = CLS_B;
        end else if (opcode_match(opcode_i, BR_MASK, BR_VAL)) begin
            class_o = CLS_BR;
        end else if (opcode_match(opcode_i, CB_MASK, CB_VAL)) begin
            class_o = CLS_CB;
        end else if (opcode_match(opcode_i, BCOND_MASK, BCOND_VAL)) begin
            class_o = CLS_BCOND;
        end else if (opcode_match(opcode_i, MOV_MASK, MOV_VAL)) begin
            class_o = CLS_MOV;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle LEGv8 control sequencer (FETCH/EXEC/HALT) with memory stalls and watchdog.
// Optional INSTR_SEQ_PERF_EN adds retired-instruction and stall-cycle counters.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int NUM_CLASSES     = 8,
    parameter int MAX_EXEC_CYCLES = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [31:0]               mem_data,
    input  logic                      mem_ready,
    input  logic [CW_W*NUM_CLASSES-1:0] dec_cw,
    input  logic [2*NUM_CLASSES-1:0]  dec_ns,
    input  logic [64*NUM_CLASSES-1:0] dec_k,
    output logic [31:0]               instruction,
    output logic [1:0]                state,
    output logic [CW_W-1:0]           controlWord,
    output logic [63:0]               K,
    output logic                      fetch,
    output logic                      halted
`ifdef INSTR_SEQ_PERF_EN
    ,
    output logic [31:0]               instr_retired,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_EXEC_CYCLES + 1);

    seq_state_e        fsm_q, fsm_d;
    logic [31:0]       ir_q, ir_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc_s;

    instr_class_e      cls_s;
    logic              cls_illegal_s;
    logic [CW_W-1:0]   sel_cw_s;
    logic [1:0]        sel_ns_s;
    logic [63:0]       sel_k_s;
    logic              exec_stall_s;
    logic [CW_W-1:0]   cw_s;
    logic [63:0]       k_s;

    instr_class_decode u_class_decode (
        .opcode_i  (ir_q[31:21]),
        .class_o   (cls_s),
        .illegal_o (cls_illegal_s)
    );

    assign sel_cw_s  = dec_cw[CW_W*int'(cls_s) +: CW_W];
    assign sel_ns_s  = dec_ns[2*int'(cls_s) +: 2];
    assign sel_k_s   = dec_k[64*int'(cls_s) +: 64];
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    assign exec_stall_s = (fsm_q == ST_EXEC) && !cls_illegal_s &&
                          (sel_cw_s[CW_EN_MEM] || sel_cw_s[CW_RAMW]) && !mem_ready;

    // Output selection and next-state decision for the sequencer
    always_comb begin
        cw_s    = NOP_CW;
        k_s     = 64'h0;
        fsm_d   = fsm_q;
        ir_d    = ir_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            ST_FETCH: begin
                cw_s = FETCH_CW;
                if (mem_ready) begin
                    cw_s[CW_PSEL_LSB +: PSEL_W] = PSEL_INC;
                    ir_d    = mem_data;
                    state_d = 2'b00;
                    cnt_d   = '0;
                    fsm_d   = ST_EXEC;
                end else begin
                    fsm_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (cls_illegal_s) begin
                    fsm_d = ST_HALT;
                end else if (exec_stall_s) begin
                    cw_s = sel_cw_s;
                    k_s  = sel_k_s;
                    cw_s[CW_REGW] = 1'b0;
                    cw_s[CW_PSEL_LSB +: PSEL_W] = PSEL_HOLD;
                end else begin
                    cw_s = sel_cw_s;
                    k_s  = sel_k_s;
                    if (sel_ns_s == 2'b00) begin
                        state_d = 2'b00;
                        cnt_d   = '0;
                        fsm_d   = ST_FETCH;
                    end else if (cnt_inc_s >= CNT_W'(MAX_EXEC_CYCLES)) begin
                        fsm_d = ST_HALT;
                    end else begin
                        state_d = sel_ns_s;
                        cnt_d   = cnt_inc_s;
                    end
                end
            end
            ST_HALT: begin
                fsm_d = ST_HALT;
            end
            default: begin
                fsm_d = ST_HALT;
            end
        endcase
    end

    // Sequencer state registers; reset drops straight back to FETCH
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_FETCH;
            ir_q    <= 32'h0;
            state_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            ir_q    <= ir_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write enables are masked while reset is held, independent of mem_ready
    assign controlWord = reset_n ? cw_s : (cw_s & ~WRITE_EN_MASK);
    assign K           = k_s;
    assign instruction = ir_q;
    assign state       = state_q;
    assign fetch       = (fsm_q == ST_FETCH);
    assign halted      = (fsm_q == ST_HALT);

`ifdef INSTR_SEQ_PERF_EN
    logic        retire_s;
    logic        stall_s;
    logic [31:0] retired_q;
    logic [31:0] stalls_q;

    assign retire_s = (fsm_q == ST_EXEC) && (fsm_d == ST_FETCH);
    assign stall_s  = ((fsm_q == ST_FETCH) && !mem_ready) || exec_stall_s;

    // Free-running performance counters, wrapping modulo 2^32
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= 32'h0;
            stalls_q  <= 32'h0;
        end else begin
            retired_q <= retired_q + {31'h0, retire_s};
            stalls_q  <= stalls_q + {31'h0, stall_s};
        end
    end

    assign instr_retired = retired_q;
    assign stall_cycles  = stalls_q;
`endif

endmodule
